// File: rtl/seg_scan_capture.sv
// Receive-side monitor for a multiplexed active-low 7-segment bus: waits for each
// digit select to settle, decodes the glyph back to a nibble and publishes whole frames.
module seg_scan_capture #(
    parameter int DIGITS        = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     AN,
    input  logic [6:0]            CATH,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_ok,
    output logic [DIGITS-1:0]     blank,
    output logic                  frame_done,
    output logic [15:0]           frame_count,
    output logic                  an_error,
    output logic                  glyph_error
);

    localparam logic [1:0] WAIT_SEL = 2'd0;
    localparam logic [1:0] SETTLE   = 2'd1;
    localparam logic [1:0] CAPTURED = 2'd2;

    localparam logic [3:0] SETTLE_N = 4'(SETTLE_CYCLES);

    logic [1:0]          state;
    logic [3:0]          cnt;
    logic [DIGITS-1:0]   an_q;
    logic [6:0]          cath_q;
    logic [DIGITS-1:0]   seen;
    logic [4*DIGITS-1:0] nib_w;
    logic [DIGITS-1:0]   ok_w;
    logic [DIGITS-1:0]   blank_w;
    logic                pub_pend;

    logic [DIGITS-1:0]   an_low;
    logic                sel_one;
    logic                an_idle;
    logic                in_changed;
    logic                do_sample;
    logic [DIGITS-1:0]   seen_next;
    logic [3:0]          g_nib;
    logic                g_ok;
    logic                g_blank;

    assign an_low     = ~an_q;
    assign sel_one    = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
    assign an_idle    = &AN;
    assign in_changed = (AN != an_q) || (CATH != cath_q);
    assign do_sample  = (state == SETTLE) && !in_changed && (cnt >= SETTLE_N);
    assign seen_next  = seen | an_low;

    always_comb begin
        g_nib   = 4'h0;
        g_ok    = 1'b1;
        g_blank = 1'b0;
        case (cath_q)
            7'b1000000: g_nib = 4'h0;
            7'b1111001: g_nib = 4'h1;
            7'b0100100: g_nib = 4'h2;
            7'b0110000: g_nib = 4'h3;
            7'b0011001: g_nib = 4'h4;
            7'b0010010: g_nib = 4'h5;
            7'b0000010: g_nib = 4'h6;
            7'b1111000: g_nib = 4'h7;
            7'b0000000: g_nib = 4'h8;
            7'b0010000: g_nib = 4'h9;
            7'b0001000: g_nib = 4'hA;
            7'b0000011: g_nib = 4'hB;
            7'b1000110: g_nib = 4'hC;
            7'b0100001: g_nib = 4'hD;
            7'b0000110: g_nib = 4'hE;
            7'b0001110: g_nib = 4'hF;
            7'b1111111: begin
                g_ok    = 1'b0;
                g_blank = 1'b1;
            end
            default:    g_ok = 1'b0;
        endcase
    end

    // Scan FSM: a position is sampled once per visit after SETTLE_CYCLES quiet cycles.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state  <= WAIT_SEL;
            cnt    <= '0;
            an_q   <= '1;
            cath_q <= '1;
        end else begin
            case (state)
                WAIT_SEL: begin
                    if (!an_idle) begin
                        state  <= SETTLE;
                        cnt    <= 4'd1;
                        an_q   <= AN;
                        cath_q <= CATH;
                    end
                end
                SETTLE: begin
                    if (an_idle) begin
                        state <= WAIT_SEL;
                        cnt   <= '0;
                    end else if (in_changed) begin
                        cnt    <= 4'd1;
                        an_q   <= AN;
                        cath_q <= CATH;
                    end else if (do_sample) begin
                        state <= CAPTURED;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                CAPTURED: begin
                    if (AN != an_q) begin
                        if (an_idle) begin
                            state <= WAIT_SEL;
                            cnt   <= '0;
                        end else begin
                            state  <= SETTLE;
                            cnt    <= 4'd1;
                            an_q   <= AN;
                            cath_q <= CATH;
                        end
                    end
                end
                default: begin
                    state <= WAIT_SEL;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Working buffer, seen mask and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            seen        <= '0;
            nib_w       <= '0;
            ok_w        <= '0;
            blank_w     <= '0;
            pub_pend    <= 1'b0;
            an_error    <= 1'b0;
            glyph_error <= 1'b0;
        end else if (pub_pend) begin
            seen     <= '0;
            pub_pend <= 1'b0;
        end else if (do_sample) begin
            if (sel_one) begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (an_low[i]) begin
                        nib_w[4*i +: 4] <= g_nib;
                        ok_w[i]         <= g_ok;
                        blank_w[i]      <= g_blank;
                    end
                end
                if (!g_ok && !g_blank) begin
                    glyph_error <= 1'b1;
                end
                seen     <= seen_next;
                pub_pend <= &seen_next;
            end else begin
                an_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            digits     <= '0;
            digit_ok   <= '0;
            blank      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pub_pend;
            if (pub_pend) begin
                digits   <= nib_w;
                digit_ok <= ok_w;
                blank    <= blank_w;
            end
        end
    end

    // frame_count survives clear; only reset zeroes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_count <= '0;
        end else if (!clear && pub_pend) begin
            frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: scans hand-built frames and checks published data,
// flags, frame counting and select-to-publish latency.
module tb_seg_scan_capture;

    logic        clk;
    logic        rst_n;
    logic [7:0]  AN;
    logic [6:0]  CATH;
    logic        clear;
    logic [31:0] digits;
    logic [7:0]  digit_ok;
    logic [7:0]  blank;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        an_error;
    logic        glyph_error;

    int n_vec = 0;
    int n_bad = 0;
    int fd_cnt = 0;

    seg_scan_capture #(.DIGITS(8), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .AN(AN), .CATH(CATH), .clear(clear),
        .digits(digits), .digit_ok(digit_ok), .blank(blank),
        .frame_done(frame_done), .frame_count(frame_count),
        .an_error(an_error), .glyph_error(glyph_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (frame_done) fd_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg(input int v);
        case (v)
            0: seg = 7'b1000000;  1: seg = 7'b1111001;  2: seg = 7'b0100100;  3: seg = 7'b0110000;
            4: seg = 7'b0011001;  5: seg = 7'b0010010;  6: seg = 7'b0000010;  7: seg = 7'b1111000;
            8: seg = 7'b0000000;  9: seg = 7'b0010000; 10: seg = 7'b0001000; 11: seg = 7'b0000011;
            12: seg = 7'b1000110; 13: seg = 7'b0100001; 14: seg = 7'b0000110; 15: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    endfunction

    task automatic gap(input int n);
        AN = '1;
        CATH = '1;
        repeat (n) @(negedge clk);
    endtask

    task automatic select(input int pos, input logic [6:0] c);
        logic [7:0] one;
        one = 8'b1 << pos;
        AN = ~one;
        CATH = c;
    endtask

    task automatic show(input int pos, input logic [6:0] c, input int dwell);
        select(pos, c);
        repeat (dwell) @(negedge clk);
    endtask

    // Counts negedges after the inputs were last changed until frame_done shows up.
    task automatic wait_fd(output int lat);
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (frame_done) begin
                lat = k;
                break;
            end
        end
    endtask

    int lat;
    int fd0;

    initial begin
        rst_n = 1'b0; AN = '1; CATH = '1; clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_digits", digits, 32'h0);
        check("rst_flags", {digit_ok, blank, frame_done, an_error, glyph_error}, 32'h0);
        check("rst_count", frame_count, 32'h0);
        rst_n = 1'b1;
        gap(10);

        // Frame 0..7, long dwell; last digit timed
        for (int p = 0; p < 7; p++) begin
            show(p, seg(p), 100);
            gap(10);
        end
        select(7, seg(7));
        wait_fd(lat);
        check("t1_latency", lat, 6);
        @(negedge clk);
        check("t1_pulse_width", frame_done, 0);
        repeat (90) @(negedge clk);
        gap(10);
        check("t1_fd_cnt", fd_cnt, 1);
        check("t1_digits", digits, 32'h76543210);
        check("t1_ok", digit_ok, 32'hFF);
        check("t1_blank", blank, 32'h00);
        check("t1_count", frame_count, 1);

        // Position 7 = 1, position 0 = 0, rest blank
        for (int p = 0; p < 8; p++) begin
            show(p, (p == 7) ? seg(1) : (p == 0) ? seg(0) : 7'b1111111, 20);
            gap(4);
        end
        gap(4);
        check("t2_digits", digits, 32'h10000000);
        check("t2_ok", digit_ok, 32'h81);
        check("t2_blank", blank, 32'h7E);
        check("t2_errs", {an_error, glyph_error}, 0);
        check("t2_count", frame_count, 2);

        // Illegal glyph at position 2
        for (int p = 0; p < 8; p++) begin
            show(p, (p == 2) ? 7'b0101010 : seg(p), 20);
            gap(4);
        end
        gap(4);
        check("t3_glyph_err", glyph_error, 1);
        check("t3_digits", digits, 32'h76543010);
        check("t3_ok", digit_ok, 32'hFB);
        check("t3_count", frame_count, 3);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_digits", digits, 32'h0);
        check("clr_flags", {digit_ok, glyph_error}, 32'h0);
        check("clr_count", frame_count, 3);

        // Two selects low: error only, nothing marked seen
        fd0 = fd_cnt;
        AN = 8'b11111100; CATH = seg(5);
        repeat (20) @(negedge clk);
        gap(4);
        check("t4_an_err", an_error, 1);
        for (int p = 2; p < 8; p++) begin
            show(p, seg(15 - p), 20);
            gap(4);
        end
        gap(4);
        check("t4_no_early_frame", fd_cnt - fd0, 0);
        for (int p = 0; p < 2; p++) begin
            show(p, seg(15 - p), 20);
            gap(4);
        end
        gap(4);
        check("t4_one_frame", fd_cnt - fd0, 1);
        check("t4_digits", digits, 32'h89ABCDEF);
        check("t4_count", frame_count, 4);
        check("t4_an_err_sticky", an_error, 1);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t5_clr_err", an_error, 0);

        // Unsettled segments on the last position must not sample
        for (int p = 0; p < 7; p++) begin
            show(p, seg(p), 20);
            gap(4);
        end
        fd0 = fd_cnt;
        select(7, seg(1));
        for (int k = 0; k < 20; k++) begin
            CATH = seg(1 + (k % 2));
            repeat (2) @(negedge clk);
        end
        check("t5_no_sample", fd_cnt - fd0 + {31'b0, frame_done}, 0);
        CATH = seg(3);
        wait_fd(lat);
        check("t5_latency", lat, 6);
        gap(6);
        check("t5_one_frame", fd_cnt - fd0, 1);
        check("t5_digits", digits, 32'h36543210);

        // Reset mid-frame discards partial data
        for (int p = 0; p < 5; p++) begin
            show(p, seg(1), 20);
            gap(4);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("t6_rst_count", frame_count, 0);
        fd0 = fd_cnt;
        for (int p = 0; p < 8; p++) begin
            show(p, seg(8), 20);
            gap(4);
        end
        gap(4);
        check("t6_one_frame", fd_cnt - fd0, 1);
        check("t6_digits", digits, 32'h88888888);
        check("t6_count", frame_count, 1);
        check("t6_ok", digit_ok, 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
